// File: rtl/vend_pkg.sv
// Shared types and encodings for the vending controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    // Coin acceptor value codes.
    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_25   = 2'd3;

    // Keypad request codes for the three product slots.
    localparam logic [3:0] CODE_SLOT1 = 4'b0011;
    localparam logic [3:0] CODE_SLOT2 = 4'b0111;
    localparam logic [3:0] CODE_SLOT3 = 4'b0001;

    // Credit units carried by a coin code; the invalid code is worth nothing.
    function automatic logic [4:0] coin_to_units(input logic [1:0] val);
        logic [4:0] units;
        case (val)
            COIN_5:  units = 5'd5;
            COIN_10: units = 5'd10;
            COIN_25: units = 5'd25;
            default: units = 5'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vend_if.sv
// Front-end / actuator bundle of the vending controller.
// Latency: n/a (wires only).
// Backpressure: dispense and change are req/ack; the controller holds until ack.
interface vend_if #(
    parameter int CREDIT_W = 6
);
    logic                coin_valid;
    logic [1:0]          coin_val;
    logic                sel_valid;
    logic [3:0]          sel;
    logic                cancel;
    logic                dispense_req;
    logic [1:0]          dispense_slot;
    logic                dispense_ack;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                change_ack;
    logic                coin_reject;
    logic                err;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    // Front end and actuators: drive strobes and acks, observe controller state.
    modport master (
        output coin_valid, coin_val, sel_valid, sel, cancel, dispense_ack, change_ack,
        input  dispense_req, dispense_slot, change_valid, change_amt,
               coin_reject, err, credit, busy
    );

    // The controller itself.
    modport slave (
        input  coin_valid, coin_val, sel_valid, sel, cancel, dispense_ack, change_ack,
        output dispense_req, dispense_slot, change_valid, change_amt,
               coin_reject, err, credit, busy
    );
endinterface

// File: rtl/vend_sel_decode.sv
// Maps a keypad request code to {valid, slot, price}.
// Latency: combinational.
// Backpressure: none.
module vend_sel_decode
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6,
    parameter int PRICE_1  = 15,
    parameter int PRICE_2  = 20,
    parameter int PRICE_3  = 25
) (
    input  logic [3:0]          sel,
    output logic                code_valid,
    output logic [1:0]          slot,
    output logic [CREDIT_W-1:0] price
);

    // Unknown codes decode to slot 0 with no price.
    always_comb begin
        code_valid = 1'b0;
        slot       = 2'd0;
        price      = '0;
        case (sel)
            CODE_SLOT1: begin
                code_valid = 1'b1;
                slot       = 2'd1;
                price      = CREDIT_W'(PRICE_1);
            end
            CODE_SLOT2: begin
                code_valid = 1'b1;
                slot       = 2'd2;
                price      = CREDIT_W'(PRICE_2);
            end
            CODE_SLOT3: begin
                code_valid = 1'b1;
                slot       = 2'd3;
                price      = CREDIT_W'(PRICE_3);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vend_controller.sv
// Vending controller: coin credit, product selection, dispense and change sequencing.
// Latency: every output is registered; an input event is visible one cycle later.
// Backpressure: dispense_req / change_valid are held until the matching ack.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE_1  = 15,
    parameter int PRICE_2  = 20,
    parameter int PRICE_3  = 25,
    parameter int CREDIT_W = 6,
    parameter int TIMEOUT  = 255
) (
    input logic clk,
    input logic rst_n,
    vend_if.slave bus
);

    localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;
    localparam int SW         = CREDIT_W + 1;          // sum width, holds the overflow bit
    localparam int TW         = $clog2(TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_nxt;
    logic [1:0]          slot_q, slot_nxt;
    logic [TW-1:0]       idle_cnt, idle_cnt_nxt;
    logic                reject_q, reject_nxt;
    logic                err_q, err_nxt;
    logic                dispense_req_q, change_valid_q, busy_q;

    logic                code_valid;
    logic [1:0]          dec_slot;
    logic [CREDIT_W-1:0] dec_price;
    logic [4:0]          coin_units;
    logic [SW-1:0]       coin_sum;
    logic                coin_real;
    logic                coin_fits;
    logic                sel_afford;
    logic                idle_expired;

    vend_sel_decode #(
        .CREDIT_W (CREDIT_W),
        .PRICE_1  (PRICE_1),
        .PRICE_2  (PRICE_2),
        .PRICE_3  (PRICE_3)
    ) u_sel_decode (
        .sel        (bus.sel),
        .code_valid (code_valid),
        .slot       (dec_slot),
        .price      (dec_price)
    );

    // A coin with the invalid value code is a no-op: never credited, never refused.
    assign coin_units   = coin_to_units(bus.coin_val);
    assign coin_real    = bus.coin_valid && (bus.coin_val != COIN_NONE);
    assign coin_sum     = SW'(credit_q) + SW'(coin_units);
    assign coin_fits    = (coin_sum <= SW'(CREDIT_MAX));
    assign sel_afford   = code_valid && (dec_price <= credit_q);
    assign idle_expired = (idle_cnt == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: cancel beats selection, selection beats coin, coin beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (coin_real && coin_fits) state_nxt = ST_CREDIT;
            end
            ST_CREDIT: begin
                if (bus.cancel)                               state_nxt = ST_CHANGE;
                else if (bus.sel_valid)                       state_nxt = sel_afford ? ST_DISPENSE : ST_CREDIT;
                else if (!bus.coin_valid && idle_expired)     state_nxt = ST_CHANGE;
            end
            ST_DISPENSE: begin
                if (bus.dispense_ack) state_nxt = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (bus.change_ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and pulse outputs for the coming cycle.
    always_comb begin
        credit_nxt     = credit_q;
        change_amt_nxt = change_amt_q;
        slot_nxt       = slot_q;
        idle_cnt_nxt   = '0;
        reject_nxt     = 1'b0;
        err_nxt        = 1'b0;
        case (state)
            ST_IDLE: begin
                err_nxt = bus.sel_valid;
                if (coin_real) begin
                    if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                    else           reject_nxt = 1'b1;
                end
            end
            ST_CREDIT: begin
                if (bus.cancel) begin
                    reject_nxt     = coin_real;
                    change_amt_nxt = credit_q;
                end else if (bus.sel_valid) begin
                    reject_nxt = coin_real;
                    if (sel_afford) begin
                        credit_nxt = credit_q - dec_price;
                        slot_nxt   = dec_slot;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_real) begin
                        if (coin_fits) credit_nxt = coin_sum[CREDIT_W-1:0];
                        else           reject_nxt = 1'b1;
                    end
                end else if (idle_expired) begin
                    change_amt_nxt = credit_q;
                end else begin
                    idle_cnt_nxt = idle_cnt + TW'(1);
                end
            end
            ST_DISPENSE: begin
                reject_nxt = coin_real;
                if (bus.dispense_ack && (credit_q != '0)) change_amt_nxt = credit_q;
            end
            ST_CHANGE: begin
                reject_nxt = coin_real;
                if (bus.change_ack) begin
                    credit_nxt     = '0;
                    change_amt_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Output registers; handshake levels follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q       <= '0;
            change_amt_q   <= '0;
            slot_q         <= '0;
            idle_cnt       <= '0;
            reject_q       <= 1'b0;
            err_q          <= 1'b0;
            dispense_req_q <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            credit_q       <= credit_nxt;
            change_amt_q   <= change_amt_nxt;
            slot_q         <= slot_nxt;
            idle_cnt       <= idle_cnt_nxt;
            reject_q       <= reject_nxt;
            err_q          <= err_nxt;
            dispense_req_q <= (state_nxt == ST_DISPENSE);
            change_valid_q <= (state_nxt == ST_CHANGE);
            busy_q         <= (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
        end
    end

    assign bus.credit        = credit_q;
    assign bus.change_amt    = change_amt_q;
    assign bus.dispense_slot = slot_q;
    assign bus.dispense_req  = dispense_req_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.busy          = busy_q;
    assign bus.coin_reject   = reject_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized and directed bench for vend_controller against a transaction-level model.
// Latency: model expects every output one cycle after the triggering inputs.
// Backpressure: acks are driven directly or at random by the bench.
module tb_vend_controller;

    localparam int CW   = 6;
    localparam int TO   = 255;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    vend_if #(.CREDIT_W(CW)) bus ();

    vend_controller #(
        .PRICE_1  (15),
        .PRICE_2  (20),
        .PRICE_3  (25),
        .CREDIT_W (CW),
        .TIMEOUT  (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: session open means credit is being collected; a pending slot means a
    // dispense is in flight; a non-negative change amount means change is owed.
    int m_credit;
    int m_slot;
    int m_change;
    int m_idle;
    bit m_session;
    bit e_reject;
    bit e_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [3:0] s);
        case (s)
            4'b0011: return 1;
            4'b0111: return 2;
            4'b0001: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int price_of(input int slot);
        case (slot)
            1:       return 15;
            2:       return 20;
            3:       return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int units_of(input logic [1:0] v);
        case (v)
            2'd1:    return 5;
            2'd2:    return 10;
            2'd3:    return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_credit  = 0;
        m_slot    = 0;
        m_change  = -1;
        m_idle    = 0;
        m_session = 1'b0;
        e_reject  = 1'b0;
        e_err     = 1'b0;
    endtask

    // Apply one cycle of inputs to the model.
    task automatic model_update();
        int  units;
        int  slot;
        bit  coin;
        units    = units_of(bus.coin_val);
        coin     = bus.coin_valid && (units != 0);
        slot     = slot_of(bus.sel);
        e_reject = 1'b0;
        e_err    = 1'b0;
        if (m_slot != 0) begin
            e_reject = coin;
            if (bus.dispense_ack) begin
                m_slot = 0;
                if (m_credit > 0) m_change = m_credit;
            end
        end else if (m_change >= 0) begin
            e_reject = coin;
            if (bus.change_ack) begin
                m_change = -1;
                m_credit = 0;
            end
        end else if (!m_session) begin
            if (bus.sel_valid) e_err = 1'b1;
            if (coin) begin
                if (units <= CMAX) begin
                    m_credit  = units;
                    m_session = 1'b1;
                    m_idle    = 0;
                end else begin
                    e_reject = 1'b1;
                end
            end
        end else if (bus.cancel) begin
            e_reject  = coin;
            m_change  = m_credit;
            m_session = 1'b0;
        end else if (bus.sel_valid) begin
            e_reject = coin;
            m_idle   = 0;
            if (slot != 0 && price_of(slot) <= m_credit) begin
                m_credit  = m_credit - price_of(slot);
                m_slot    = slot;
                m_session = 1'b0;
            end else begin
                e_err = 1'b1;
            end
        end else if (bus.coin_valid) begin
            m_idle = 0;
            if (coin) begin
                if (m_credit + units <= CMAX) m_credit = m_credit + units;
                else                          e_reject = 1'b1;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_change  = m_credit;
                m_session = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("dispense_req", 32'(bus.dispense_req), 32'(m_slot != 0));
        if (m_slot != 0) check("dispense_slot", 32'(bus.dispense_slot), m_slot);
        check("change_valid", 32'(bus.change_valid), 32'(m_change >= 0));
        if (m_change >= 0) check("change_amt", 32'(bus.change_amt), m_change);
        check("credit", 32'(bus.credit), m_credit);
        check("busy", 32'(bus.busy), 32'((m_slot != 0) || (m_change >= 0)));
        check("coin_reject", 32'(bus.coin_reject), 32'(e_reject));
        check("err", 32'(bus.err), 32'(e_err));
    endtask

    task automatic drive(input bit cv, input bit [1:0] val, input bit sv, input bit [3:0] s,
                         input bit can, input bit dack, input bit cack);
        bus.coin_valid   = cv;
        bus.coin_val     = val;
        bus.sel_valid    = sv;
        bus.sel          = s;
        bus.cancel       = can;
        bus.dispense_ack = dack;
        bus.change_ack   = cack;
    endtask

    // One clock: model consumes the inputs at the edge, outputs are compared just after.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic coin(input bit [1:0] val);
        drive(1, val, 0, 4'd0, 0, 0, 0);
        step();
    endtask

    task automatic select(input bit [3:0] s);
        drive(0, 2'd0, 1, s, 0, 0, 0);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 2'd0, 0, 4'd0, 0, 0, 0);
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dispense_req"}, 32'(bus.dispense_req), 0);
        check({tag, "_dispense_slot"}, 32'(bus.dispense_slot), 0);
        check({tag, "_change_valid"}, 32'(bus.change_valid), 0);
        check({tag, "_change_amt"}, 32'(bus.change_amt), 0);
        check({tag, "_coin_reject"}, 32'(bus.coin_reject), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_credit"}, 32'(bus.credit), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    // Reset lands mid-cycle so the outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        drive(0, 2'd0, 0, 4'd0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #2;
        check_reset_values(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int p;
        int len;
        int code_pick;
        logic [3:0] rsel;
        rst_n = 1'b0;
        drive(0, 2'd0, 0, 4'd0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        do_reset("rst");

        // 10 + 10, buy slot 1, receive 5 change.
        coin(2'd2);
        coin(2'd2);
        check("tp1_credit", 32'(bus.credit), 20);
        select(4'b0011);
        check("tp1_req", 32'(bus.dispense_req), 1);
        check("tp1_slot", 32'(bus.dispense_slot), 1);
        check("tp1_debit", 32'(bus.credit), 5);
        drive(0, 2'd0, 0, 4'd0, 0, 1, 0);
        step();
        check("tp1_chg_vld", 32'(bus.change_valid), 1);
        check("tp1_chg_amt", 32'(bus.change_amt), 5);
        drive(0, 2'd0, 0, 4'd0, 0, 0, 1);
        step();
        check("tp1_end_credit", 32'(bus.credit), 0);
        check("tp1_end_busy", 32'(bus.busy), 0);

        // Exact credit: slot 3 for 25, no change phase.
        coin(2'd3);
        select(4'b0001);
        check("tp2_slot", 32'(bus.dispense_slot), 3);
        drive(0, 2'd0, 0, 4'd0, 0, 1, 0);
        step();
        check("tp2_no_change", 32'(bus.change_valid), 0);
        check("tp2_idle_busy", 32'(bus.busy), 0);

        // Insufficient credit, then an unknown code, then cancel.
        coin(2'd2);
        select(4'b0111);
        check("tp3_err_price", 32'(bus.err), 1);
        check("tp3_credit", 32'(bus.credit), 10);
        select(4'b1111);
        check("tp3_err_code", 32'(bus.err), 1);
        drive(0, 2'd0, 0, 4'd0, 1, 0, 0);
        step();
        check("tp3_cancel_amt", 32'(bus.change_amt), 10);
        drive(0, 2'd0, 0, 4'd0, 0, 0, 1);
        step();

        // Inactivity refund.
        coin(2'd1);
        idle(TO - 1);
        check("tp4_before_timeout", 32'(bus.change_valid), 0);
        idle(1);
        check("tp4_timeout_vld", 32'(bus.change_valid), 1);
        check("tp4_timeout_amt", 32'(bus.change_amt), 5);
        drive(0, 2'd0, 0, 4'd0, 0, 0, 1);
        step();

        // Credit ceiling, then a coin during dispense.
        coin(2'd3);
        coin(2'd3);
        coin(2'd3);
        check("tp5_reject", 32'(bus.coin_reject), 1);
        check("tp5_credit", 32'(bus.credit), 50);
        select(4'b0011);
        coin(2'd2);
        check("tp5_disp_reject", 32'(bus.coin_reject), 1);
        check("tp5_disp_credit", 32'(bus.credit), 35);
        drive(0, 2'd0, 0, 4'd0, 0, 1, 0);
        step();
        drive(0, 2'd0, 0, 4'd0, 0, 0, 1);
        step();

        // Cancel with a coin in the same cycle, then reset in CHANGE.
        coin(2'd2);
        drive(1, 2'd3, 0, 4'd0, 1, 0, 0);
        step();
        check("tp6_cancel_amt", 32'(bus.change_amt), 10);
        check("tp6_cancel_reject", 32'(bus.coin_reject), 1);
        do_reset("tp6_rst");
        select(4'b0011);
        check("tp6_idle_err", 32'(bus.err), 1);

        // Random traffic in bursts of varying density; quiet bursts exercise the timeout.
        for (int b = 0; b < 24; b++) begin
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 8;
                2:       p = 30;
                default: p = 60;
            endcase
            len = (p == 0) ? 300 : 120;
            for (int c = 0; c < len; c++) begin
                code_pick = $urandom_range(0, 3);
                case (code_pick)
                    0:       rsel = 4'b0011;
                    1:       rsel = 4'b0111;
                    2:       rsel = 4'b0001;
                    default: rsel = 4'($urandom_range(0, 15));
                endcase
                drive(($urandom_range(0, 99) < p),
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 99) < p / 2),
                      rsel,
                      ($urandom_range(0, 99) < p / 6),
                      ($urandom_range(0, 99) < 40),
                      ($urandom_range(0, 99) < 40));
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequential controller for the vending datapath. It accumulates coin credit and decodes the 4-bit product request code into a dispense slot and price. It then sequences the dispense handshake and returns change. It sits between the coin acceptor/keypad front end and the dispense/change actuators.

## Interface
- PRICE_1, default 15: price of slot 1 (credit units of 5¢ ×1, i.e. raw units).
- PRICE_2, default 20: price of slot 2.
- PRICE_3, default 25: price of slot 3.
- CREDIT_W, default 6: credit register width; CREDIT_MAX = 2^CREDIT_W−1.
- TIMEOUT, default 255: idle cycles in CREDIT before auto-refund.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin strobe.
- coin_val  in  2  1=5, 2=10, 3=25; 0 is invalid and ignored.
- sel_valid  in  1  one-cycle selection strobe.
- sel  in  4  product request code.
- cancel  in  1  one-cycle refund request.
- dispense_req  out  1  held until dispense_ack.
- dispense_slot  out  2  slot being dispensed (1..3).
- dispense_ack  in  1  actuator done.
- change_valid  out  1  held until change_ack.
- change_amt  out  CREDIT_W  amount to return.
- change_ack  in  1  change paid.
- coin_reject  out  1  one-cycle pulse: coin refused.
- err  out  1  one-cycle pulse: invalid code or insufficient credit.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- Decode: sel=4'b0011 → slot 1; 4'b0111 → slot 2; 4'b0001 → slot 3; any other code → invalid (slot 0).
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE, credit=0:
  - An accepted coin → CREDIT.
  - sel_valid → err pulse; stay in IDLE.
  - cancel is ignored.
- CREDIT, coins: a coin is accepted when credit+value ≤ CREDIT_MAX and added to credit. Otherwise it is refused with a coin_reject pulse and credit is unchanged.
- CREDIT, selections:
  - sel_valid with an invalid code → err pulse; stay.
  - Valid code with price > credit → err pulse; stay.
  - Otherwise credit −= price, dispense_slot is latched, and the FSM goes to DISPENSE.
- CREDIT, refunds: cancel, or TIMEOUT consecutive cycles with no coin_valid/sel_valid → CHANGE with change_amt=credit.
- DISPENSE: dispense_req=1 until the dispense_ack cycle. Then go to CHANGE if credit>0, else IDLE.
- CHANGE: change_valid=1 with change_amt=credit until the change_ack cycle. Then credit=0 → IDLE.
- Coins arriving in DISPENSE or CHANGE are rejected (coin_reject). sel_valid and cancel are ignored in those states.
- Simultaneous events in CREDIT, by priority:
  - cancel has highest priority: go to CHANGE; any coin is rejected and any selection is ignored.
  - sel_valid with coin_valid: the selection is processed and the coin is rejected.
- A coin with coin_val=0 produces neither a credit change nor coin_reject.
- The timeout counter clears on entry to CREDIT and on every coin_valid or sel_valid.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, credit=0, dispense_req=0, dispense_slot=0, change_valid=0, change_amt=0, coin_reject=0, err=0, busy=0, timeout counter=0.
- Coin strobe in cycle N → credit is updated and visible in N+1; coin_reject pulses in N+1.
- Accepted selection in N → dispense_req=1 and the debited credit in N+1.
- An ack asserted in cycle M drops the corresponding req/valid in M+1. The next state is entered in M+1.
- The refund fires in the cycle after the TIMEOUT-th idle cycle.
- A reset assertion mid-handshake drops dispense_req/change_valid immediately (asynchronously). Credit is lost; this is intended.

## Structure
- Shared package vend_pkg holds:
  - the state enum;
  - the coin-value encoding and the slot code localparams (4'b0011/0111/0001);
  - a coin_to_units function.
- One sub-module, vend_sel_decode: combinational sel → {valid, slot[1:0], price}, parameterised by the PRICE_* parameters.

## Test plan
- Coins 10+10 then sel=4'b0011 → credit 20 → dispense_req slot 1 next cycle. After the ack: change_valid with change_amt=5; after the ack: IDLE with credit=0.
- Coins 25 then sel=4'b0001 → dispense slot 3. The FSM goes straight to IDLE with no change_valid.
- Coin 10 then sel=4'b0111 (price 20) → err pulse, credit stays 10. Then sel=4'b1111 → err pulse.
- Credit 5, then TIMEOUT idle cycles → change_valid with change_amt=5 in cycle TIMEOUT+1. With CREDIT_W=6, three 25 coins → the third is rejected and credit=50.
- Coin during DISPENSE → coin_reject, credit unchanged. Simultaneous cancel+coin in CREDIT → CHANGE with the prior credit; the coin is rejected.
- rst_n low during CHANGE → all outputs return to their reset values asynchronously; state=IDLE once rst_n releases.
